// File: rtl/smd_pad_encoder_mp_pkg.sv
// Shared definitions for the multi-port Mega Drive pad encoder: pin positions
// inside a port's 6-bit slice, read-sequence phases, fixed row patterns, the
// button bundle and the row-selection helper.
package smd_pad_encoder_mp_pkg;

    // Bit position of each console pin inside a port slice {p1,p2,p3,p4,p6,p9}
    localparam int P1 = 5;
    localparam int P2 = 4;
    localparam int P3 = 3;
    localparam int P4 = 2;
    localparam int P6 = 1;
    localparam int P9 = 0;

    // Fixed upper-nibble patterns of the TH-low rows
    localparam logic [5:0] ROW_ID   = 6'b111100;
    localparam logic [5:0] ROW_ZERO = 6'b000000;

    // Read-sequence phase, advanced on each falling TH edge
    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_SEL1 = 3'd1,
        PH_SEL2 = 3'd2,
        PH_EXT  = 3'd3,
        PH_ID   = 3'd4
    } phase_t;

    // One port's buttons, all active low
    typedef struct packed {
        logic up;
        logic dw;
        logic lf;
        logic rg;
        logic a;
        logic b;
        logic c;
        logic st;
        logic x;
        logic y;
        logic z;
        logic md;
    } btn_t;

    // Pin pattern answered for a given TH level and phase
    function automatic logic [5:0] pad_row(input logic th, input phase_t ph, input btn_t btn);
        logic [5:0] row;
        row = 6'b111111;
        if (th) begin
            if (ph == PH_EXT) begin
                row[P1] = btn.z;
                row[P2] = btn.y;
                row[P3] = btn.x;
                row[P4] = btn.md;
            end else begin
                row[P1] = btn.up;
                row[P2] = btn.dw;
                row[P3] = btn.lf;
                row[P4] = btn.rg;
            end
            row[P6] = btn.b;
            row[P9] = btn.c;
        end else begin
            case (ph)
                PH_EXT:  row = ROW_ZERO;
                PH_ID:   row = ROW_ID;
                default: begin
                    row     = ROW_ZERO;
                    row[P1] = btn.up;
                    row[P2] = btn.dw;
                end
            endcase
            row[P6] = btn.a;
            row[P9] = btn.st;
        end
        return row;
    endfunction

endpackage

// File: rtl/smd_pad_encoder_mp_if.sv
// Console/pad bundle for NUM_PORTS controller ports: TH select and buttons in,
// data pins and six-button status out. The encoder uses the slave view.
interface smd_pad_encoder_mp_if #(
    parameter int NUM_PORTS = 2
);
    logic [NUM_PORTS-1:0]   p7;
    logic [NUM_PORTS-1:0]   up;
    logic [NUM_PORTS-1:0]   dw;
    logic [NUM_PORTS-1:0]   lf;
    logic [NUM_PORTS-1:0]   rg;
    logic [NUM_PORTS-1:0]   a;
    logic [NUM_PORTS-1:0]   b;
    logic [NUM_PORTS-1:0]   c;
    logic [NUM_PORTS-1:0]   st;
    logic [NUM_PORTS-1:0]   x;
    logic [NUM_PORTS-1:0]   y;
    logic [NUM_PORTS-1:0]   z;
    logic [NUM_PORTS-1:0]   md;
    logic [NUM_PORTS-1:0]   force_3btn;
    logic [6*NUM_PORTS-1:0] p;
    logic [NUM_PORTS-1:0]   six_mode;

    modport master (
        output p7, up, dw, lf, rg, a, b, c, st, x, y, z, md, force_3btn,
        input  p, six_mode
    );

    modport slave (
        input  p7, up, dw, lf, rg, a, b, c, st, x, y, z, md, force_3btn,
        output p, six_mode
    );
endinterface

// File: rtl/smd_pad_encoder_mp_channel.sv
// One controller port: synchronisers, TH edge detect, phase counter with
// inactivity timeout, 3-button lock captured during reset, registered pins.
module smd_pad_encoder_mp_channel
    import smd_pad_encoder_mp_pkg::*;
#(
    parameter int TMO         = 15000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       p7,
    input  btn_t       btn,
    input  logic       force_3btn,
    output logic [5:0] p,
    output logic       six_mode
);

    localparam int             TW    = $clog2(TMO + 1);
    localparam logic [TW-1:0]  TMO_V = TW'(TMO);
    localparam logic [TW-1:0]  ONE_V = TW'(1'b1);

    logic [SYNC_STAGES-1:0]         th_sync_r;
    btn_t [SYNC_STAGES-1:0]         btn_sync_r;
    logic [SYNC_STAGES-1:0]         md_lock_sync_r;
    logic                           th_s;
    btn_t                           btn_s;
    logic                           th_d_r;
    btn_t                           btn_d_r;
    phase_t                         cnt_r;
    phase_t                         cnt_nxt_s;
    logic [TW-1:0]                  timer_r;
    logic [TW-1:0]                  timer_nxt_s;
    logic                           edge_s;
    logic                           fall_s;
    logic                           lock3_r;
    logic [5:0]                     p_r;
    logic                           six_mode_r;

    assign th_s  = th_sync_r[SYNC_STAGES-1];
    assign btn_s = btn_sync_r[SYNC_STAGES-1];

    // TH and button synchronisers, forced idle-high while in reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            th_sync_r  <= '1;
            btn_sync_r <= '1;
        end else begin
            th_sync_r  <= {th_sync_r[SYNC_STAGES-2:0], p7};
            btn_sync_r <= {btn_sync_r[SYNC_STAGES-2:0], btn};
        end
    end

    // Mode synchroniser kept running through reset so the lock sees the held button
    always_ff @(posedge clk) begin
        md_lock_sync_r <= {md_lock_sync_r[SYNC_STAGES-2:0], btn.md};
    end

    // Next phase and timer: lock/force clear, falling edge steps, any edge beats timeout
    always_comb begin
        edge_s      = th_s ^ th_d_r;
        fall_s      = th_d_r & ~th_s;
        timer_nxt_s = timer_r;
        cnt_nxt_s   = cnt_r;
        if (edge_s) begin
            timer_nxt_s = '0;
        end else if (timer_r != TMO_V) begin
            timer_nxt_s = timer_r + ONE_V;
        end else begin
            timer_nxt_s = timer_r;
        end
        if (lock3_r || force_3btn) begin
            cnt_nxt_s = PH_IDLE;
        end else if (fall_s) begin
            case (cnt_r)
                PH_IDLE: cnt_nxt_s = PH_SEL1;
                PH_SEL1: cnt_nxt_s = PH_SEL2;
                PH_SEL2: cnt_nxt_s = PH_EXT;
                PH_EXT:  cnt_nxt_s = PH_ID;
                PH_ID:   cnt_nxt_s = PH_SEL1;
                default: cnt_nxt_s = PH_IDLE;
            endcase
        end else if (edge_s) begin
            cnt_nxt_s = cnt_r;
        end else if (timer_r == TMO_V) begin
            cnt_nxt_s = PH_IDLE;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Phase state, timer, edge history and button pipeline; lock loaded in reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r   <= PH_IDLE;
            timer_r <= '0;
            th_d_r  <= 1'b1;
            btn_d_r <= '1;
            lock3_r <= ~md_lock_sync_r[SYNC_STAGES-1];
        end else begin
            cnt_r   <= cnt_nxt_s;
            timer_r <= timer_nxt_s;
            th_d_r  <= th_s;
            btn_d_r <= btn_s;
            lock3_r <= lock3_r;
        end
    end

    // Registered pin row and six-button status
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_r        <= 6'b111111;
            six_mode_r <= md_lock_sync_r[SYNC_STAGES-1] & ~force_3btn;
        end else begin
            p_r        <= pad_row(th_d_r, cnt_r, btn_d_r);
            six_mode_r <= ~lock3_r & ~force_3btn;
        end
    end

    assign p        = p_r;
    assign six_mode = six_mode_r;

endmodule

// File: rtl/smd_pad_encoder_mp.sv
// Multi-port Mega Drive six-button pad encoder: one independent channel per
// port, with the port vectors sliced out of the shared interface bundle.
module smd_pad_encoder_mp
    import smd_pad_encoder_mp_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int CLK_HZ      = 10_000_000,
    parameter int TIMEOUT_US  = 1500,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    smd_pad_encoder_mp_if.slave  bus
);

    localparam int TMO = CLK_HZ / 1_000_000 * TIMEOUT_US;

    logic [6*NUM_PORTS-1:0] p_all_s;
    logic [NUM_PORTS-1:0]   six_all_s;

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
        btn_t btn_s;

        assign btn_s = {bus.up[k], bus.dw[k], bus.lf[k], bus.rg[k],
                        bus.a[k],  bus.b[k],  bus.c[k],  bus.st[k],
                        bus.x[k],  bus.y[k],  bus.z[k],  bus.md[k]};

        smd_pad_encoder_mp_channel #(
            .TMO         (TMO),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_channel (
            .clk        (clk),
            .rst_n      (rst_n),
            .p7         (bus.p7[k]),
            .btn        (btn_s),
            .force_3btn (bus.force_3btn[k]),
            .p          (p_all_s[6*k +: 6]),
            .six_mode   (six_all_s[k])
        );
    end

    assign bus.p        = p_all_s;
    assign bus.six_mode = six_all_s;

endmodule
